serial_adder: RTL and testbench

- Bit-serial adder that accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake.
- Feeds one operand bit pair per cycle, LSB first, into a single full-adder cell, and keeps the carry in a register between cycles.
- Shifts the sum bits into a result register and presents S, CO and OVF through an output valid/ready handshake.
- Sits directly upstream of the full-adder cell, as its sequencing stage: an area-cheap alternative to a ripple chain of full adders.

---
 rtl/serial_adder.sv | 107 ++++++++++
 tb/tb_serial_adder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, one bit per cycle.
// Ports: IN_VALID/IN_READY + A/B/CI in, OUT_VALID/OUT_READY + S/CO/OVF out.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             OVF
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             sum_bit;
  logic             carry_nx;
  logic [WIDTH-1:0] r_nx;

  always_comb begin
    sum_bit  = a_sh[0] ^ b_sh[0] ^ carry;
    carry_nx = (a_sh[0] & b_sh[0])
             | (a_sh[0] & carry)
             | (b_sh[0] & carry);
    // sum bit enters at the MSB so the
    // result is aligned after WIDTH steps
    r_nx = (r_sh >> 1)
         | (WIDTH'(sum_bit) << (WIDTH - 1));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      IN_READY  <= 1'b1;
      OUT_VALID <= 1'b0;
      S         <= '0;
      CO        <= 1'b0;
      OVF       <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      r_sh      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (IN_VALID) begin
            a_sh     <= A;
            b_sh     <= B;
            carry    <= CI;
            cnt      <= '0;
            IN_READY <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          r_sh  <= r_nx;
          carry <= carry_nx;
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB
            S         <= r_nx;
            CO        <= carry_nx;
            OVF       <= carry ^ carry_nx;
            cnt       <= '0;
            OUT_VALID <= 1'b1;
            state     <= HOLD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            IN_READY  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          OUT_VALID <= 1'b0;
          IN_READY  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed + random checks of serial_adder
// at WIDTH 1, 8 and 16 sharing one clock/reset.
module tb_serial_adder;

  logic        CLK;
  logic        RST_N;
  logic        iv [3];
  logic        ir [3];
  logic        ov [3];
  logic        ordy [3];
  logic        ci_in [3];
  logic        co [3];
  logic        ovf [3];
  logic [31:0] a_in [3];
  logic [31:0] b_in [3];
  logic [31:0] s_all [3];
  logic [0:0]  s1;
  logic [7:0]  s8;
  logic [15:0] s16;

  int nerr = 0;
  int nchk = 0;

  assign s_all[0] = 32'(s1);
  assign s_all[1] = 32'(s8);
  assign s_all[2] = 32'(s16);

  serial_adder #(.WIDTH(1)) u_w1 (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(iv[0]), .IN_READY(ir[0]),
    .A(a_in[0][0:0]), .B(b_in[0][0:0]),
    .CI(ci_in[0]),
    .OUT_VALID(ov[0]), .OUT_READY(ordy[0]),
    .S(s1), .CO(co[0]), .OVF(ovf[0])
  );

  serial_adder #(.WIDTH(8)) u_w8 (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(iv[1]), .IN_READY(ir[1]),
    .A(a_in[1][7:0]), .B(b_in[1][7:0]),
    .CI(ci_in[1]),
    .OUT_VALID(ov[1]), .OUT_READY(ordy[1]),
    .S(s8), .CO(co[1]), .OVF(ovf[1])
  );

  serial_adder #(.WIDTH(16)) u_w16 (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(iv[2]), .IN_READY(ir[2]),
    .A(a_in[2][15:0]), .B(b_in[2][15:0]),
    .CI(ci_in[2]),
    .OUT_VALID(ov[2]), .OUT_READY(ordy[2]),
    .S(s16), .CO(co[2]), .OVF(ovf[2])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ready(input int k);
    int n;
    n = 0;
    while (!ir[k] && n < 100) begin
      tick();
      n++;
    end
    if (!ir[k]) chk("ready_timeout", 32'(ir[k]), 1);
  endtask

  // cycles from acceptance edge to OUT_VALID
  task automatic wait_ov(
    input  int k,
    output int lat
  );
    lat = 0;
    while (!ov[k] && lat < 100) begin
      tick();
      lat++;
    end
    if (!ov[k]) chk("ov_timeout", 32'(ov[k]), 1);
  endtask

  task automatic accept(
    input int          k,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        ci,
    input logic        rdy
  );
    wait_ready(k);
    a_in[k]  = a;
    b_in[k]  = b;
    ci_in[k] = ci;
    ordy[k]  = rdy;
    iv[k]    = 1'b1;
    tick();
    iv[k] = 1'b0;
  endtask

  task automatic run_op(
    input int          k,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        ci,
    input int          stall
  );
    int          w;
    int          lat;
    logic [31:0] m;
    logic [32:0] sum;
    logic [31:0] es;
    logic        eco;
    logic        eovf;
    w = (k == 0) ? 1 : (k == 1) ? 8 : 16;
    m = (32'd1 << w) - 32'd1;
    sum = {1'b0, a & m} + {1'b0, b & m}
        + 33'(ci);
    es   = sum[31:0] & m;
    eco  = sum[w];
    eovf = (a[w-1] == b[w-1])
        && (es[w-1] != a[w-1]);
    accept(k, a, b, ci, stall == 0);
    wait_ov(k, lat);
    chk("lat", 32'(lat), 32'(w));
    chk("s", s_all[k], es);
    chk("co", 32'(co[k]), 32'(eco));
    chk("ovf", 32'(ovf[k]), 32'(eovf));
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_ov", 32'(ov[k]), 1);
      chk("stall_s", s_all[k], es);
    end
    ordy[k] = 1'b1;
    tick();
    chk("drop_ov", 32'(ov[k]), 0);
    chk("back_ir", 32'(ir[k]), 1);
  endtask

  initial begin
    int   lat;
    logic seen;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 0; ordy[k] = 1; ci_in[k] = 0;
      a_in[k] = '0; b_in[k] = '0;
    end
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ir", 32'(ir[1]), 1);
    chk("rst_ov", 32'(ov[1]), 0);
    chk("rst_s", s_all[1], 0);
    chk("rst_co", 32'(co[1]), 0);
    chk("rst_ovf", 32'(ovf[1]), 0);
    RST_N = 1'b1;
    tick();

    // basic sum, latency 8, 1-cycle valid
    run_op(1, 'h5A, 'h3C, 0, 0);
    chk("5a3c_s", s_all[1], 'h96);
    chk("5a3c_co", 32'(co[1]), 0);
    chk("5a3c_ovf", 32'(ovf[1]), 1);

    run_op(1, 'hFF, 'h01, 0, 0);
    chk("ff01_s", s_all[1], 'h00);
    chk("ff01_co", 32'(co[1]), 1);
    chk("ff01_ovf", 32'(ovf[1]), 0);

    run_op(1, 'h80, 'h80, 0, 0);
    chk("8080_s", s_all[1], 'h00);
    chk("8080_co", 32'(co[1]), 1);
    chk("8080_ovf", 32'(ovf[1]), 1);

    run_op(1, 'h00, 'h00, 1, 0);
    chk("ci_s", s_all[1], 'h01);
    chk("ci_co", 32'(co[1]), 0);
    chk("ci_ovf", 32'(ovf[1]), 0);

    run_op(1, 'hFF, 'hFF, 1, 0);
    chk("wrap_s", s_all[1], 'hFF);
    chk("wrap_co", 32'(co[1]), 1);

    // backpressure with ignored IN_VALID
    accept(1, 'h12, 'h34, 0, 0);
    wait_ov(1, lat);
    chk("bp_lat", 32'(lat), 8);
    chk("bp_s", s_all[1], 'h46);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        a_in[1] = 'hAA;
        iv[1]   = 1'b1;
      end
      tick();
      iv[1] = 1'b0;
      chk("bp_ov", 32'(ov[1]), 1);
      chk("bp_ir", 32'(ir[1]), 0);
      chk("bp_hold_s", s_all[1], 'h46);
    end
    ordy[1] = 1'b1;
    tick();
    chk("bp_rel_ov", 32'(ov[1]), 0);
    chk("bp_rel_ir", 32'(ir[1]), 1);
    chk("bp_keep_s", s_all[1], 'h46);
    tick();
    chk("bp_idle_ir", 32'(ir[1]), 1);

    // reset in the middle of RUN
    accept(1, 'h0F, 'h01, 0, 1);
    repeat (4) tick();
    RST_N = 1'b0;
    #1;
    chk("mid_ir", 32'(ir[1]), 1);
    chk("mid_ov", 32'(ov[1]), 0);
    chk("mid_s", s_all[1], 0);
    chk("mid_co", 32'(co[1]), 0);
    chk("mid_ovf", 32'(ovf[1]), 0);
    tick();
    RST_N = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (ov[1]) seen = 1'b1;
    end
    chk("mid_no_ov", 32'(seen), 0);
    run_op(1, 'h02, 'h03, 0, 0);
    chk("post_rst_s", s_all[1], 'h05);

    // operands change after acceptance
    accept(1, 'h10, 'h20, 0, 1);
    a_in[1] = 'hFF;
    b_in[1] = 'hFF;
    wait_ov(1, lat);
    chk("chg_lat", 32'(lat), 8);
    chk("chg_s", s_all[1], 'h30);
    chk("chg_co", 32'(co[1]), 0);
    tick();

    // WIDTH=1 corner cases
    run_op(0, 1, 1, 1, 0);
    chk("w1_111_s", s_all[0], 1);
    chk("w1_111_co", 32'(co[0]), 1);
    chk("w1_111_ovf", 32'(ovf[0]), 0);
    run_op(0, 0, 0, 1, 0);
    chk("w1_001_ovf", 32'(ovf[0]), 1);
    run_op(0, 1, 1, 0, 0);
    chk("w1_110_s", s_all[0], 0);
    chk("w1_110_ovf", 32'(ovf[0]), 1);

    run_op(2, 'h7FFF, 'h0001, 0, 2);
    chk("w16_s", s_all[2], 'h8000);
    chk("w16_ovf", 32'(ovf[2]), 1);

    // random regression across widths
    for (int n = 0; n < 1000; n++) begin
      int k;
      int st;
      k  = $urandom_range(0, 2);
      st = ($urandom_range(0, 3) == 0)
         ? $urandom_range(1, 4) : 0;
      run_op(k, $urandom, $urandom,
             1'($urandom_range(0, 1)), st);
    end

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
